// File: rtl/tube_scan_driver.sv
// Multiplexed seven-segment driver: one digit per div_clk rise, one blank clk between digits,
// double-buffered display value committed at frame wrap. Define TUBE_LZ_BLANK_EN for leading-zero blanking.
module tube_scan_driver #(
  parameter int DIGITS         = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        div_clk,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  output logic        ready,
  output logic        frame_done,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        seg_dp
);

  localparam logic [2:0] LAST    = 3'(DIGITS - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [7:0] AN_OFF  = AN_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic {DRIVE, BLANK} state_t;

  state_t      state;
  logic        div_s1, div_s2, div_d;
  logic        tick;
  logic [2:0]  idx;
  logic [31:0] pend_data, disp_data;
  logic [7:0]  pend_dp, disp_dp;
  logic        pend_vld;
  logic [7:0]  lz_mask;
  logic [3:0]  cur_nib;
  logic [6:0]  seg_on, seg_drv;
  logic        dp_on, dp_drv;
  logic [7:0]  an_drv;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign tick = div_s2 & ~div_d;

`ifdef TUBE_LZ_BLANK_EN
  // Scan from the top digit down; a digit is blank while everything at and above it is zero with no dp.
  always_comb begin
    logic run;
    run     = 1'b1;
    lz_mask = '0;
    for (int k = 7; k >= 0; k--) begin
      if (k < DIGITS) begin
        run        = run & (disp_data[4*k +: 4] == 4'h0) & ~disp_dp[k];
        lz_mask[k] = run & (k != 0);
      end
    end
  end
`else
  assign lz_mask = '0;
`endif

  assign cur_nib = disp_data[{idx, 2'b00} +: 4];
  assign seg_on  = hex7(cur_nib) & ~{7{lz_mask[idx]}};
  assign dp_on   = disp_dp[idx] & ~lz_mask[idx];
  assign seg_drv = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
  assign dp_drv  = SEG_ACTIVE_LOW ? ~dp_on : dp_on;
  assign an_drv  = AN_ACTIVE_LOW ? ~(8'b1 << idx) : (8'b1 << idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_s1     <= 1'b0;
      div_s2     <= 1'b0;
      div_d      <= 1'b0;
      state      <= DRIVE;
      idx        <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      disp_data  <= '0;
      disp_dp    <= '0;
      pend_vld   <= 1'b0;
      ready      <= 1'b1;
      frame_done <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      seg_dp     <= DP_OFF;
    end else begin
      div_s1     <= div_clk;
      div_s2     <= div_s1;
      div_d      <= div_s2;
      frame_done <= 1'b0;

      // Commit requires pend_vld already set, so it never overlaps an accepted load.
      if (load && !pend_vld) begin
        pend_data <= data;
        pend_dp   <= dp;
        pend_vld  <= 1'b1;
        ready     <= 1'b0;
      end

      case (state)
        DRIVE: begin
          if (tick) begin
            state  <= BLANK;
            idx    <= (idx == LAST) ? 3'd0 : idx + 3'd1;
            an     <= AN_OFF;
            seg    <= SEG_OFF;
            seg_dp <= DP_OFF;
            if (idx == LAST && pend_vld) begin
              disp_data  <= pend_data;
              disp_dp    <= pend_dp;
              pend_vld   <= 1'b0;
              ready      <= 1'b1;
              frame_done <= 1'b1;
            end
          end else begin
            an     <= an_drv;
            seg    <= seg_drv;
            seg_dp <= dp_drv;
          end
        end
        default: begin
          state  <= DRIVE;
          an     <= an_drv;
          seg    <= seg_drv;
          seg_dp <= dp_drv;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tube_scan_driver.sv
// Randomized bench for tube_scan_driver against a frame/digit-level model of the display.
module tb_tube_scan_driver;
  localparam int DIGITS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_clk = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dp = '0;
  logic        ready, frame_done, seg_dp;
  logic [7:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;
  int fd_seen = 0;
  int fd_exp = 0;

  int          m_idx;
  logic [31:0] m_disp_data, m_pend_data;
  logic [7:0]  m_disp_dp, m_pend_dp;
  bit          m_pvld;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  tube_scan_driver #(.DIGITS(DIGITS), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .div_clk(div_clk), .load(load), .data(data), .dp(dp),
    .ready(ready), .frame_done(frame_done), .an(an), .seg(seg), .seg_dp(seg_dp)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && frame_done) fd_seen++;

  function automatic bit lz(input int k);
`ifdef TUBE_LZ_BLANK_EN
    if (k == 0) return 1'b0;
    for (int j = k; j < DIGITS; j++)
      if (m_disp_data[4*j +: 4] != 4'h0 || m_disp_dp[j]) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [6:0] exp_seg(input int k);
    if (lz(k)) return 7'h7F;
    return ~hex_tab[m_disp_data[4*k +: 4]];
  endfunction

  function automatic logic exp_dp(input int k);
    if (lz(k)) return 1'b1;
    return ~m_disp_dp[k];
  endfunction

  function automatic logic [7:0] exp_an(input int k);
    logic [7:0] one;
    one = 8'b1;
    return ~(one << k);
  endfunction

  task automatic model_reset();
    m_idx = 0; m_disp_data = '0; m_disp_dp = '0; m_pend_data = '0; m_pend_dp = '0; m_pvld = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; div_clk = 1'b0; load = 1'b0;
    model_reset();
    #1;
    checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an got %h want ff", an); end
    checks++; if (seg !== 7'h7F || seg_dp !== 1'b1) begin errors++; $display("FAIL reset_seg got %h/%b want 7f/1", seg, seg_dp); end
    checks++; if (ready !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_hs got rdy=%b fd=%b want 1/0", ready, frame_done); end
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (an !== 8'hFE || seg !== 7'h40 || seg_dp !== 1'b1) begin errors++; $display("FAIL post_reset got an=%h seg=%h dp=%b want fe/40/1", an, seg, seg_dp); end
    repeat (10) @(posedge clk); #1;
    checks++; if (an !== 8'hFE || seg !== 7'h40 || ready !== 1'b1) begin errors++; $display("FAIL idle_hold got an=%h seg=%h rdy=%b want fe/40/1", an, seg, ready); end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p);
    load = 1'b1; data = d; dp = p;
    @(posedge clk); #1;
    load = 1'b0;
    if (!m_pvld) begin m_pend_data = d; m_pend_dp = p; m_pvld = 1'b1; end
    checks++; if (ready !== !m_pvld) begin errors++; $display("FAIL load_ready got %b want %b", ready, !m_pvld); end
  endtask

  // One div_clk period; optionally presents load on the cycle the tick is consumed.
  task automatic do_rise(input bit ld, input logic [31:0] d, input logic [7:0] p);
    bit commit, pv_old;
    div_clk = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (an !== exp_an(m_idx)) begin errors++; $display("FAIL pre_tick_an got %h want %h", an, exp_an(m_idx)); end
    if (ld) begin load = 1'b1; data = d; dp = p; end
    @(posedge clk); #1;
    load = 1'b0;
    pv_old = m_pvld;
    commit = (m_idx == DIGITS - 1) && pv_old;
    if (commit) begin m_disp_data = m_pend_data; m_disp_dp = m_pend_dp; m_pvld = 1'b0; fd_exp++; end
    if (ld && !pv_old) begin m_pend_data = d; m_pend_dp = p; m_pvld = 1'b1; end
    m_idx = (m_idx + 1) % DIGITS;
    checks++; if (an !== 8'hFF || seg !== 7'h7F || seg_dp !== 1'b1) begin errors++; $display("FAIL blank got an=%h seg=%h dp=%b want ff/7f/1", an, seg, seg_dp); end
    checks++; if (frame_done !== commit || ready !== !m_pvld) begin errors++; $display("FAIL commit_hs got fd=%b rdy=%b want %b/%b", frame_done, ready, commit, !m_pvld); end
    @(posedge clk); #1;
    checks++; if (an !== exp_an(m_idx)) begin errors++; $display("FAIL digit_an idx=%0d got %h want %h", m_idx, an, exp_an(m_idx)); end
    checks++; if (seg !== exp_seg(m_idx) || seg_dp !== exp_dp(m_idx)) begin errors++; $display("FAIL digit_seg idx=%0d got %h/%b want %h/%b", m_idx, seg, seg_dp, exp_seg(m_idx), exp_dp(m_idx)); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL fd_width got %b want 0", frame_done); end
    repeat ($urandom_range(1, 3)) @(posedge clk); #1;
    div_clk = 1'b0;
    repeat ($urandom_range(4, 8)) @(posedge clk); #1;
  endtask

  task automatic test_scan();
    for (int i = 0; i < DIGITS + 1; i++) do_rise(1'b0, '0, '0);
  endtask

  task automatic test_load_commit();
    int f0;
    do_rise(1'b0, '0, '0);
    do_rise(1'b0, '0, '0);
    do_load(32'h89ABCDEF, 8'h01);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL first_load_ready got %b want 0", ready); end
    do_load(32'h0, 8'h00);
    f0 = fd_exp;
    while (fd_exp == f0) do_rise(1'b0, '0, '0);
    checks++; if (seg !== 7'h0E || seg_dp !== 1'b0) begin errors++; $display("FAIL digit0_F got %h/%b want 0e/0", seg, seg_dp); end
    while (m_idx != DIGITS - 1) do_rise(1'b0, '0, '0);
    checks++; if (seg !== 7'h00) begin errors++; $display("FAIL digit7_8 got %h want 00", seg); end
  endtask

  task automatic test_coincident();
    int f0;
    while (m_pvld || m_idx != DIGITS - 1) do_rise(1'b0, '0, '0);
    f0 = fd_exp;
    do_rise(1'b1, 32'h13579BDF, 8'hA5);
    checks++; if (fd_exp != f0 || !m_pvld) begin errors++; $display("FAIL coincident_model got fd=%0d pvld=%b want %0d/1", fd_exp, m_pvld, f0); end
    for (int i = 0; i < DIGITS; i++) do_rise(1'b0, '0, '0);
    checks++; if (seg !== 7'h0E) begin errors++; $display("FAIL coincident_commit got %h want 0e", seg); end
  endtask

  task automatic test_lz();
    int f0;
    do_load(32'h00000120, 8'h00);
    f0 = fd_exp;
    while (fd_exp == f0) do_rise(1'b0, '0, '0);
    for (int k = 1; k < DIGITS; k++) begin
      do_rise(1'b0, '0, '0);
`ifdef TUBE_LZ_BLANK_EN
      if (k >= 3) begin checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL lz_blank k=%0d got %h want 7f", k, seg); end end
`else
      if (k >= 3) begin checks++; if (seg !== 7'h40) begin errors++; $display("FAIL lz_zero k=%0d got %h want 40", k, seg); end end
`endif
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) do_load($urandom, 8'($urandom));
      do_rise($urandom_range(0, 7) == 0, $urandom, 8'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    do_load($urandom, 8'($urandom));
    do_rise(1'b0, '0, '0);
    do_rise(1'b0, '0, '0);
    test_reset();
    for (int i = 0; i < DIGITS + 1; i++) do_rise(1'b0, '0, '0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_load_commit();
    test_coincident();
    test_lz();
    test_random();
    test_reset_mid();
    checks++; if (fd_seen != fd_exp) begin errors++; $display("FAIL fd_count got %0d want %0d", fd_seen, fd_exp); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tube_scan_driver.md
# tube_scan_driver

Time-multiplexed seven-segment tube driver for the board display. Consumes the slow square wave produced by the tube clock divider (`div_clk`), advances one digit per `div_clk` rising edge, and drives shared segment lines plus per-digit anode selects. New display values are accepted through a load/ready handshake and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `DIGITS`, 8, number of scanned digits, legal range 2..8.
- `SEG_ACTIVE_LOW`, 1, 1 = segments/dp lit when 0.
- `AN_ACTIVE_LOW`, 1, 1 = anode selected when 0.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `div_clk`  in  1  scan rate square wave from clock divider; treated as asynchronous.
- `load`  in  1  request to capture `data`/`dp`.
- `data`  in  32  eight hex nibbles; nibble k (`data[4k+3:4k]`) shown on digit k.
- `dp`  in  8  decimal point per digit; bit k on digit k.
- `ready`  out  1  high when `load` will be accepted.
- `frame_done`  out  1  one-cycle pulse when a pending value is committed.
- `an`  out  8  anode selects; bit k = digit k.
- `seg`  out  7  segments, `seg[0]`=a … `seg[6]`=g.
- `seg_dp`  out  1  decimal point segment.

## Operation
- `div_clk` passes a 2-flop synchronizer plus a delay flop; `tick` = synced high & delayed low (rising edge, one clk wide).
- Digit index `idx` (3 bits) resets to 0; on `tick` increments, wrapping DIGITS-1 -> 0.
- Two-state scan FSM: DRIVE (reset state) and BLANK. `tick` in DRIVE -> BLANK for exactly one clk (all anodes inactive, segments/dp inactive), then -> DRIVE showing new `idx`. `tick` in BLANK is impossible for legal `div_clk` rates (≥4 clk per half-period); no requirement.
- Storage: `pend_data`/`pend_dp` (pending), `disp_data`/`disp_dp` (displayed), `pend_vld`.
- Handshake: `load & ready` captures `data`,`dp` into pending, sets `pend_vld`; `ready` = `~pend_vld`. `load` while `ready`=0 ignored, pending unchanged.
- Commit: on `tick` with wrap (idx DIGITS-1 -> 0) and `pend_vld` already 1 at that cycle, pending -> displayed, `pend_vld` cleared, `frame_done` pulses. A load accepted in the same cycle as the wrap tick is committed at the following wrap.
- Hex decode, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Inverted when `SEG_ACTIVE_LOW`=1. `seg_dp` = `disp_dp[idx]`, polarity likewise.
- `an` one-hot on `idx` in DRIVE; inverted when `AN_ACTIVE_LOW`=1. Bits ≥ DIGITS always inactive.

## Timing
- Reset values: `an` all inactive (8'hFF with defaults), `seg` inactive (7'h7F), `seg_dp` inactive (1), `ready`=1, `frame_done`=0, idx=0, FSM=DRIVE, displayed/pending = 0, `pend_vld`=0. After reset release digit 0 shows "0" (seg 7'h40 active-low) immediately.
- `div_clk` rise to `tick`: 3 clk edges. `tick` to blank outputs: 1 clk; to new digit on `an`/`seg`: 2 clk. All outputs registered.
- `load` accepted at edge N: `ready`=0 from edge N+1. Commit edge M: `frame_done`=1 and `ready`=1 in cycle M+1; new value visible on digit 0 at M+2.
- Reset mid-scan or with pending value: all state returns to reset values; pending discarded.

## Configuration
- `TUBE_LZ_BLANK_EN` defined: leading-zero blanking. Digit k (k>0) is blanked (segments and dp inactive, anode still cycles) when nibble k and all higher nibbles below DIGITS are 0 and their `dp` bits are 0. Digit 0 never blanked.
- Undefined: every digit always decoded, zeros shown.

## Test plan
- Reset release, DIGITS=8, defaults -> `an`=8'hFE, `seg`=7'h40, `ready`=1; stays until first `div_clk` rise.
- Eight `div_clk` rises -> `an` walks FE,FD,…,7F, back to FE, each preceded by one clk of `an`=FF, new digit 2 clk after `tick`.
- `load` with `data`=32'h89ABCDEF, `dp`=8'h01 mid-frame -> `ready` low; digits unchanged until wrap; then `frame_done` pulse, digit 0 `seg`=7'h0E (F active-low), `seg_dp`=0, digit 7 `seg`=7'h00.
- Second `load` while `ready`=0 with 32'h0 -> ignored; displayed value after commit equals first load.
- `load` coincident with wrap tick, `pend_vld`=0 -> no commit that frame; commit at next wrap.
- With `TUBE_LZ_BLANK_EN`, `data`=32'h00000120, `dp`=0 -> digits 3..7 `seg`=7'h7F; digits 0..2 show 0,2,1. Without: digits 3..7 show 7'h40.
